// File: rtl/lazy_seq_emitter_pkg.sv
// Shared widths, sequence record layout and job-tracking state encodings for
// the lazy sequence emitter and the sequence writer that unpacks its records.
package lazy_seq_emitter_pkg;

    localparam int JOB_LEN_LOG2    = 6;
    localparam int SEQ_LL_BITS     = 12;
    localparam int SEQ_ML_BITS     = 12;
    localparam int SEQ_OFFSET_BITS = 16;
    localparam int SEQ_REC_BITS    = SEQ_LL_BITS + SEQ_ML_BITS + SEQ_OFFSET_BITS + SEQ_ML_BITS + 2;

    typedef enum logic {
        RUN          = 1'b0,
        WAIT_RELEASE = 1'b1
    } job_state_e;

    // First member lands in the MSBs: {overlap, eoj, delim, offset, ml, ll}.
    typedef struct packed {
        logic [SEQ_ML_BITS-1:0]     overlap_len;
        logic                       eoj;
        logic                       delim;
        logic [SEQ_OFFSET_BITS-1:0] offset;
        logic [SEQ_ML_BITS-1:0]     ml;
        logic [SEQ_LL_BITS-1:0]     ll;
    } seq_rec_t;

    function automatic seq_rec_t make_rec(
        input logic [SEQ_LL_BITS-1:0]     ll,
        input logic [SEQ_ML_BITS-1:0]     ml,
        input logic [SEQ_OFFSET_BITS-1:0] offset,
        input logic                       delim,
        input logic                       eoj,
        input logic [SEQ_ML_BITS-1:0]     overlap_len
    );
        seq_rec_t r;
        r.overlap_len = overlap_len;
        r.eoj         = eoj;
        r.delim       = delim;
        r.offset      = offset;
        r.ml          = ml;
        r.ll          = ll;
        return r;
    endfunction

endpackage

// File: rtl/lazy_seq_emitter_if.sv
// Summary input, head feedback and sequence-record handshake bundle of the
// lazy sequence emitter; slave is the emitter side, master its surroundings.
interface lazy_seq_emitter_if;
    import lazy_seq_emitter_pkg::*;

    logic                       i_summary_done;
    logic [JOB_LEN_LOG2-1:0]    i_seq_head_ptr;
    logic [SEQ_LL_BITS-1:0]     i_summary_ll;
    logic [SEQ_ML_BITS-1:0]     i_summary_ml;
    logic [SEQ_OFFSET_BITS-1:0] i_summary_offset;
    logic                       i_summary_delim;
    logic                       i_summary_eoj;
    logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len;
    logic                       i_move_to_next_job;
    logic [JOB_LEN_LOG2-1:0]    i_move_forward;
    logic                       o_next_head_valid;
    logic [JOB_LEN_LOG2-1:0]    o_next_head_ptr;
    logic                       o_job_release;
    logic                       o_stall;
    logic                       o_overflow;
    logic                       o_seq_valid;
    logic                       i_seq_ready;
    logic [SEQ_LL_BITS-1:0]     o_seq_ll;
    logic [SEQ_ML_BITS-1:0]     o_seq_ml;
    logic [SEQ_OFFSET_BITS-1:0] o_seq_offset;
    logic                       o_seq_delim;
    logic                       o_seq_eoj;
    logic [SEQ_ML_BITS-1:0]     o_seq_overlap_len;

    modport master (
        output i_summary_done, i_seq_head_ptr, i_summary_ll, i_summary_ml, i_summary_offset,
               i_summary_delim, i_summary_eoj, i_summary_overlap_len, i_move_to_next_job,
               i_move_forward, i_seq_ready,
        input  o_next_head_valid, o_next_head_ptr, o_job_release, o_stall, o_overflow,
               o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_delim, o_seq_eoj,
               o_seq_overlap_len
    );

    modport slave (
        input  i_summary_done, i_seq_head_ptr, i_summary_ll, i_summary_ml, i_summary_offset,
               i_summary_delim, i_summary_eoj, i_summary_overlap_len, i_move_to_next_job,
               i_move_forward, i_seq_ready,
        output o_next_head_valid, o_next_head_ptr, o_job_release, o_stall, o_overflow,
               o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_delim, o_seq_eoj,
               o_seq_overlap_len
    );

endinterface

// File: rtl/lazy_seq_emitter_seq_sync_fifo.sv
// Synchronous FIFO with a registered head word and an occupancy count; the
// caller guarantees wr_en only when space exists (or a pop coincides).
module seq_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] head_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    // The incoming word bypasses into the head when it becomes the oldest entry.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
        if (wr_en && (count == '0 || (rd_en && count == CW'(1))))
            head_q <= wr_data;
        else if (rd_en)
            head_q <= mem[rd_ptr + AW'(1)];
    end

    assign rd_data = head_q;

endmodule

// File: rtl/lazy_seq_emitter.sv
// Converts lazy summary results into buffered sequence records, feeds the next
// head pointer back upstream and tracks job release / stall / overflow.
module lazy_seq_emitter
    import lazy_seq_emitter_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int STALL_SLACK = 5
) (
    input  logic               clk,
    input  logic               rst,
    lazy_seq_emitter_if.slave  bus
);
    localparam int               CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(FIFO_DEPTH - STALL_SLACK);

    seq_rec_t                rec_in, rec_out;
    logic [CNT_W-1:0]        count, count_next, pend_q, pend_next;
    logic                    qualify, push, pop, drop;
    job_state_e              state_q;
    logic                    stall_q, ovf_q, rel_p1, nh_vld_p1;
    logic [JOB_LEN_LOG2-1:0] nh_ptr_p1;

    assign rec_in = make_rec(bus.i_summary_ll, bus.i_summary_ml, bus.i_summary_offset,
                             bus.i_summary_delim, bus.i_summary_eoj, bus.i_summary_overlap_len);

    // Literal-only summaries that do not close the job carry nothing for the writer.
    assign qualify    = bus.i_summary_done && (bus.i_summary_eoj || bus.i_summary_ml != '0) && !rst;
    assign pop        = (count != '0) && bus.i_seq_ready && !rst;
    assign push       = qualify && (count != DEPTH_C || pop);
    assign drop       = qualify && !push;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign pend_next  = pend_q + CNT_W'(push && rec_in.eoj) - CNT_W'(pop && rec_out.eoj);

    seq_sync_fifo #(
        .WIDTH (SEQ_REC_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (rec_in),
        .rd_en   (pop),
        .rd_data (rec_out),
        .count   (count)
    );

    // Stage p1: registered control outputs and job-tracking FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pend_q    <= '0;
            rel_p1    <= 1'b0;
            stall_q   <= 1'b0;
            ovf_q     <= 1'b0;
            nh_vld_p1 <= 1'b0;
            nh_ptr_p1 <= '0;
        end else begin
            stall_q   <= (count_next >= STALL_TH);
            rel_p1    <= pop && rec_out.eoj;
            pend_q    <= pend_next;
            nh_vld_p1 <= bus.i_summary_done && !bus.i_move_to_next_job;
            if (drop) ovf_q <= 1'b1;
            if (bus.i_summary_done)
                nh_ptr_p1 <= bus.i_move_to_next_job ? '0 : bus.i_seq_head_ptr + bus.i_move_forward;
            case (state_q)
                RUN:          if (push && rec_in.eoj) state_q <= WAIT_RELEASE;
                WAIT_RELEASE: if (pend_next == '0)    state_q <= RUN;
                default:                              state_q <= RUN;
            endcase
        end
    end

    assign bus.o_next_head_valid = nh_vld_p1;
    assign bus.o_next_head_ptr   = nh_ptr_p1;
    assign bus.o_job_release     = rel_p1;
    assign bus.o_stall           = stall_q;
    assign bus.o_overflow        = ovf_q;
    assign bus.o_seq_valid       = (count != '0);
    assign bus.o_seq_ll          = rec_out.ll;
    assign bus.o_seq_ml          = rec_out.ml;
    assign bus.o_seq_offset      = rec_out.offset;
    assign bus.o_seq_delim       = rec_out.delim;
    assign bus.o_seq_eoj         = rec_out.eoj;
    assign bus.o_seq_overlap_len = rec_out.overlap_len;

endmodule

// File: tb/tb_lazy_seq_emitter.sv
// Directed bench for lazy_seq_emitter: record emission, head feedback, wrap,
// stall/overflow on a full FIFO, job release timing and mid-job reset.
module tb_lazy_seq_emitter;
    import lazy_seq_emitter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    lazy_seq_emitter_if bus();

    lazy_seq_emitter #(
        .FIFO_DEPTH  (8),
        .STALL_SLACK (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int ll, input int ml, input int off, input logic delim,
                       input logic eoj, input int ovl, input int head, input int fwd,
                       input logic mv);
        bus.i_summary_done        = 1'b1;
        bus.i_summary_ll          = SEQ_LL_BITS'(ll);
        bus.i_summary_ml          = SEQ_ML_BITS'(ml);
        bus.i_summary_offset      = SEQ_OFFSET_BITS'(off);
        bus.i_summary_delim       = delim;
        bus.i_summary_eoj         = eoj;
        bus.i_summary_overlap_len = SEQ_ML_BITS'(ovl);
        bus.i_seq_head_ptr        = JOB_LEN_LOG2'(head);
        bus.i_move_forward        = JOB_LEN_LOG2'(fwd);
        bus.i_move_to_next_job    = mv;
    endtask

    task automatic idle;
        bus.i_summary_done = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle();
        bus.i_seq_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.i_seq_ready = 1'b0;
        put(1, 2, 3, 1'b0, 1'b1, 0, 5, 1, 1'b1);
        tick();
        checks++; if (bus.o_seq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.o_seq_valid); end
        checks++; if (bus.o_next_head_valid !== 1'b0) begin errors++; $display("FAIL reset_nhv got=%0b exp=0", bus.o_next_head_valid); end
        checks++; if (bus.o_next_head_ptr !== 6'd0) begin errors++; $display("FAIL reset_ptr got=%0d exp=0", bus.o_next_head_ptr); end
        checks++; if (bus.o_job_release !== 1'b0) begin errors++; $display("FAIL reset_release got=%0b exp=0", bus.o_job_release); end
        checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", bus.o_stall); end
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", bus.o_overflow); end
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL reset_state got=%0d exp=0", dut.state_q); end
        rst = 1'b0;
        idle();
        tick();
        checks++; if (bus.o_seq_valid !== 1'b0) begin errors++; $display("FAIL reset_discard got=%0b exp=0", bus.o_seq_valid); end
    endtask

    task automatic test_basic;
        do_reset();
        bus.i_seq_ready = 1'b1;
        put(5, 12, 'h40, 1'b1, 1'b0, 3, 10, 17, 1'b0);
        tick();
        idle();
        checks++; if (bus.o_seq_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", bus.o_seq_valid); end
        checks++; if (bus.o_seq_ll !== 12'd5) begin errors++; $display("FAIL basic_ll got=%0d exp=5", bus.o_seq_ll); end
        checks++; if (bus.o_seq_ml !== 12'd12) begin errors++; $display("FAIL basic_ml got=%0d exp=12", bus.o_seq_ml); end
        checks++; if (bus.o_seq_offset !== 16'h40) begin errors++; $display("FAIL basic_offset got=%0h exp=40", bus.o_seq_offset); end
        checks++; if (bus.o_seq_delim !== 1'b1) begin errors++; $display("FAIL basic_delim got=%0b exp=1", bus.o_seq_delim); end
        checks++; if (bus.o_seq_overlap_len !== 12'd3) begin errors++; $display("FAIL basic_overlap got=%0d exp=3", bus.o_seq_overlap_len); end
        checks++; if (bus.o_seq_eoj !== 1'b0) begin errors++; $display("FAIL basic_eoj got=%0b exp=0", bus.o_seq_eoj); end
        checks++; if (bus.o_next_head_valid !== 1'b1) begin errors++; $display("FAIL basic_nhv got=%0b exp=1", bus.o_next_head_valid); end
        checks++; if (bus.o_next_head_ptr !== 6'd27) begin errors++; $display("FAIL basic_ptr got=%0d exp=27", bus.o_next_head_ptr); end
        tick();
        checks++; if (bus.o_seq_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got=%0b exp=0", bus.o_seq_valid); end
        checks++; if (bus.o_next_head_valid !== 1'b0) begin errors++; $display("FAIL basic_nhv_pulse got=%0b exp=0", bus.o_next_head_valid); end
    endtask

    task automatic test_drop_and_eoj;
        do_reset();
        bus.i_seq_ready = 1'b1;
        put(7, 0, 0, 1'b0, 1'b0, 0, 3, 4, 1'b0);
        tick();
        checks++; if (bus.o_seq_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got=%0b exp=0", bus.o_seq_valid); end
        checks++; if (bus.o_next_head_valid !== 1'b1) begin errors++; $display("FAIL drop_nhv got=%0b exp=1", bus.o_next_head_valid); end
        checks++; if (bus.o_next_head_ptr !== 6'd7) begin errors++; $display("FAIL drop_ptr got=%0d exp=7", bus.o_next_head_ptr); end
        put(9, 0, 0, 1'b0, 1'b1, 0, 20, 2, 1'b1);
        tick();
        idle();
        checks++; if (bus.o_seq_valid !== 1'b1) begin errors++; $display("FAIL eoj_valid got=%0b exp=1", bus.o_seq_valid); end
        checks++; if (bus.o_seq_ll !== 12'd9) begin errors++; $display("FAIL eoj_ll got=%0d exp=9", bus.o_seq_ll); end
        checks++; if (bus.o_seq_ml !== 12'd0) begin errors++; $display("FAIL eoj_ml got=%0d exp=0", bus.o_seq_ml); end
        checks++; if (bus.o_seq_eoj !== 1'b1) begin errors++; $display("FAIL eoj_flag got=%0b exp=1", bus.o_seq_eoj); end
        checks++; if (bus.o_next_head_valid !== 1'b0) begin errors++; $display("FAIL eoj_nhv got=%0b exp=0", bus.o_next_head_valid); end
        checks++; if (bus.o_next_head_ptr !== 6'd0) begin errors++; $display("FAIL eoj_ptr got=%0d exp=0", bus.o_next_head_ptr); end
        checks++; if (dut.state_q !== WAIT_RELEASE) begin errors++; $display("FAIL eoj_state_wait got=%0d exp=1", dut.state_q); end
        tick();
        checks++; if (bus.o_job_release !== 1'b1) begin errors++; $display("FAIL eoj_release got=%0b exp=1", bus.o_job_release); end
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL eoj_state_run got=%0d exp=0", dut.state_q); end
        tick();
        checks++; if (bus.o_job_release !== 1'b0) begin errors++; $display("FAIL eoj_release_pulse got=%0b exp=0", bus.o_job_release); end
    endtask

    task automatic test_wrap;
        do_reset();
        put(1, 0, 0, 1'b0, 1'b0, 0, 61, 5, 1'b0);
        tick();
        idle();
        checks++; if (bus.o_next_head_ptr !== 6'd2) begin errors++; $display("FAIL wrap_ptr got=%0d exp=2", bus.o_next_head_ptr); end
        checks++; if (bus.o_next_head_valid !== 1'b1) begin errors++; $display("FAIL wrap_nhv got=%0b exp=1", bus.o_next_head_valid); end
    endtask

    task automatic test_fill_overflow;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            put(k, k, k, 1'b0, 1'b0, 0, 0, 1, 1'b0);
            tick();
            checks++;
            if (bus.o_stall !== (k >= 3)) begin
                errors++; $display("FAIL fill_stall[%0d] got=%0b exp=%0b", k, bus.o_stall, (k >= 3));
            end
        end
        put(100, 100, 0, 1'b0, 1'b0, 0, 0, 1, 1'b0);
        tick();
        idle();
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b exp=1", bus.o_overflow); end
        bus.i_seq_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.o_seq_valid !== 1'b1 || bus.o_seq_ll !== 12'(k + 1)) begin
                errors++; $display("FAIL ovf_order[%0d] got=%0b/%0d exp=1/%0d", k, bus.o_seq_valid, bus.o_seq_ll, k + 1);
            end
            tick();
        end
        checks++; if (bus.o_seq_valid !== 1'b0) begin errors++; $display("FAIL ovf_count got=%0b exp=0", bus.o_seq_valid); end
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", bus.o_overflow); end
        checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL ovf_stall_clear got=%0b exp=0", bus.o_stall); end
    endtask

    task automatic test_full_push_pop;
        int exp_ll[8] = '{2, 3, 4, 5, 6, 7, 8, 50};
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            put(k, 1, 0, 1'b0, 1'b0, 0, 0, 1, 1'b0);
            tick();
        end
        put(50, 1, 0, 1'b0, 1'b0, 0, 0, 1, 1'b0);
        bus.i_seq_ready = 1'b1;
        tick();
        idle();
        bus.i_seq_ready = 1'b0;
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL full_pp_ovf got=%0b exp=0", bus.o_overflow); end
        checks++; if (bus.o_stall !== 1'b1) begin errors++; $display("FAIL full_pp_stall got=%0b exp=1", bus.o_stall); end
        bus.i_seq_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.o_seq_valid !== 1'b1 || bus.o_seq_ll !== 12'(exp_ll[k])) begin
                errors++; $display("FAIL full_pp_order[%0d] got=%0b/%0d exp=1/%0d", k, bus.o_seq_valid, bus.o_seq_ll, exp_ll[k]);
            end
            tick();
        end
        checks++; if (bus.o_seq_valid !== 1'b0) begin errors++; $display("FAIL full_pp_empty got=%0b exp=0", bus.o_seq_valid); end
    endtask

    task automatic test_release;
        do_reset();
        put(1, 3, 0, 1'b0, 1'b0, 0, 0, 1, 1'b0);
        tick();
        put(2, 3, 0, 1'b0, 1'b0, 0, 0, 1, 1'b0);
        tick();
        put(3, 4, 0, 1'b0, 1'b1, 0, 0, 0, 1'b1);
        tick();
        idle();
        checks++; if (dut.state_q !== WAIT_RELEASE) begin errors++; $display("FAIL rel_state_wait got=%0d exp=1", dut.state_q); end
        for (int i = 0; i < 6; i++) begin
            bus.i_seq_ready = (i % 2 == 0);
            tick();
            checks++;
            if (bus.o_job_release !== (i == 4)) begin
                errors++; $display("FAIL rel_pulse[%0d] got=%0b exp=%0b", i, bus.o_job_release, (i == 4));
            end
            if (i == 3) begin
                checks++; if (dut.state_q !== WAIT_RELEASE) begin errors++; $display("FAIL rel_state_hold got=%0d exp=1", dut.state_q); end
            end
            if (i == 4) begin
                checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL rel_state_run got=%0d exp=0", dut.state_q); end
            end
        end
        bus.i_seq_ready = 1'b0;
    endtask

    task automatic test_reset_mid_job;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            put(k, 2, 0, 1'b0, 1'b0, 0, 0, 1, 1'b0);
            tick();
        end
        put(4, 2, 0, 1'b0, 1'b1, 0, 0, 0, 1'b1);
        tick();
        idle();
        checks++; if (dut.state_q !== WAIT_RELEASE) begin errors++; $display("FAIL rstmid_pre_state got=%0d exp=1", dut.state_q); end
        checks++; if (bus.o_stall !== 1'b1) begin errors++; $display("FAIL rstmid_pre_stall got=%0b exp=1", bus.o_stall); end
        rst = 1'b1;
        bus.i_seq_ready = 1'b1;
        tick();
        checks++; if (bus.o_seq_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%0b exp=0", bus.o_seq_valid); end
        checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%0b exp=0", bus.o_stall); end
        checks++; if (bus.o_job_release !== 1'b0) begin errors++; $display("FAIL rstmid_release got=%0b exp=0", bus.o_job_release); end
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL rstmid_state got=%0d exp=0", dut.state_q); end
        rst = 1'b0;
        tick();
        checks++; if (bus.o_job_release !== 1'b0) begin errors++; $display("FAIL rstmid_release_after got=%0b exp=0", bus.o_job_release); end
        checks++; if (bus.o_seq_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_after got=%0b exp=0", bus.o_seq_valid); end
        bus.i_seq_ready = 1'b0;
    endtask

    initial begin
        bus.i_seq_ready = 1'b0;
        put(0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        idle();
        test_reset();
        test_basic();
        test_drop_and_eoj();
        test_wrap();
        test_fill_overflow();
        test_full_push_pop();
        test_release();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
